// File: rtl/execute_pkg.sv
// Shared types and default sizes for the execute stage and its multiplier.
package execute_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_ADDR_WIDTH = 2;
    localparam int SHAMT_WIDTH        = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
module shift_add_multiplier
    import execute_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_count;
    logic               r_busy;

    logic [2*WIDTH-1:0] w_partial;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    assign w_partial  = r_mplier[0] ? r_mcand : '0;
    assign w_acc_next = r_acc + w_partial;
    assign w_last     = (r_count == WIDTH'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= w_last ? '0 : r_count + WIDTH'(1);
            r_busy   <= !w_last;
        end
    end

    // The final partial product is added combinationally so the caller can
    // capture the full product on the same edge that ends the last iteration.
    assign done    = r_busy && w_last;
    assign product = w_acc_next;

endmodule

// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU plus optional iterative multiply (EXECUTE_MUL_EN),
// driving a one-cycle register-file writeback pulse and carry/zero flags.
module execute_unit
    import execute_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issueValid,
    output logic                  issueReady,
    input  logic [2:0]            opcode,
    input  logic [WIDTH-1:0]      aOperand,
    input  logic [WIDTH-1:0]      bOperand,
    input  logic [ADDR_WIDTH-1:0] destAddress,
    output logic [WIDTH-1:0]      result,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic                  writeEnable,
    output logic                  carry,
    output logic                  zero
);

    opcode_t                w_op;
    logic                   w_accept;
    logic                   w_alu_wb;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_diff;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [2*WIDTH-1:0]     w_shl_ext;
    logic [2*WIDTH-1:0]     w_shr_ext;
    logic [WIDTH-1:0]       w_alu_result;
    logic                   w_alu_carry;

    logic                   w_mul_done;
    logic [2*WIDTH-1:0]     w_mul_product;
    logic [ADDR_WIDTH-1:0]  w_mul_dest;

    logic [WIDTH-1:0]       r_result;
    logic [ADDR_WIDTH-1:0]  r_write_address;
    logic                   r_write_enable;
    logic                   r_carry;
    logic                   r_zero;

    assign w_op     = opcode_t'(opcode);
    assign w_accept = issueValid && issueReady;
    assign w_alu_wb = w_accept && (w_op != OP_MUL);

    // Widened shifts leave the last bit shifted out sitting just past the result.
    assign w_sum     = {1'b0, aOperand} + {1'b0, bOperand};
    assign w_diff    = {1'b0, aOperand} - {1'b0, bOperand};
    assign w_shamt   = bOperand[SHAMT_WIDTH-1:0];
    assign w_shl_ext = {{WIDTH{1'b0}}, aOperand} << w_shamt;
    assign w_shr_ext = {aOperand, {WIDTH{1'b0}}} >> w_shamt;

    always_comb begin
        w_alu_result = '0;
        w_alu_carry  = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_alu_result = w_sum[WIDTH-1:0];
                w_alu_carry  = w_sum[WIDTH];
            end
            OP_SUB: begin
                w_alu_result = w_diff[WIDTH-1:0];
                w_alu_carry  = w_diff[WIDTH];
            end
            OP_AND: w_alu_result = aOperand & bOperand;
            OP_OR:  w_alu_result = aOperand | bOperand;
            OP_XOR: w_alu_result = aOperand ^ bOperand;
            OP_SHL: begin
                w_alu_result = w_shl_ext[WIDTH-1:0];
                w_alu_carry  = w_shl_ext[WIDTH];
            end
            OP_SHR: begin
                w_alu_result = w_shr_ext[2*WIDTH-1:WIDTH];
                w_alu_carry  = w_shr_ext[WIDTH-1];
            end
            default: begin
                w_alu_result = '0;
                w_alu_carry  = 1'b0;
            end
        endcase
    end

`ifdef EXECUTE_MUL_EN
    state_t                r_state;
    state_t                w_state_next;
    logic                  w_mul_start;
    logic [ADDR_WIDTH-1:0] r_mul_dest;

    assign w_mul_start = w_accept && (w_op == OP_MUL);
    assign issueReady  = !reset && (r_state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_mul_dest <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_mul_start) begin
                r_mul_dest <= destAddress;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_mul_start) w_state_next = MULT;
            MULT:    if (w_mul_done)  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    shift_add_multiplier #(
        .WIDTH (WIDTH)
    ) u_multiplier (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (aOperand),
        .b       (bOperand),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    assign w_mul_dest = r_mul_dest;
`else
    // Opcode 7 is swallowed without a writeback, so the unit never stalls.
    assign issueReady    = !reset;
    assign w_mul_done    = 1'b0;
    assign w_mul_product = '0;
    assign w_mul_dest    = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_result        <= '0;
            r_write_address <= '0;
            r_write_enable  <= 1'b0;
            r_carry         <= 1'b0;
            r_zero          <= 1'b0;
        end else begin
            r_write_enable <= 1'b0;
            if (w_alu_wb) begin
                r_result        <= w_alu_result;
                r_write_address <= destAddress;
                r_write_enable  <= 1'b1;
                r_carry         <= w_alu_carry;
                r_zero          <= (w_alu_result == '0);
            end else if (w_mul_done) begin
                r_result        <= w_mul_product[WIDTH-1:0];
                r_write_address <= w_mul_dest;
                r_write_enable  <= 1'b1;
                r_carry         <= |w_mul_product[2*WIDTH-1:WIDTH];
                r_zero          <= (w_mul_product[WIDTH-1:0] == '0);
            end
        end
    end

    assign result       = r_result;
    assign writeAddress = r_write_address;
    assign writeEnable  = r_write_enable;
    assign carry        = r_carry;
    assign zero         = r_zero;

endmodule
